// File: rtl/cd_pkg.sv
// rtl/cd_pkg.sv - shared types and widths for the CD upload-zone write path
package cd_pkg;

  localparam int Z80_AW   = 16;
  localparam int FIX_AW   = 17;
  localparam int SDRAM_AW = 25;

  // One queued SDRAM write: word address, data and byte enables {upper, lower}
  typedef struct packed {
    logic [SDRAM_AW-2:0] addr;
    logic [15:0]         data;
    logic [1:0]          be;
  } upload_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } upload_state_t;

endpackage

// File: rtl/cd_upload_fifo.sv
// rtl/cd_upload_fifo.sv - single-clock queue of upload entries with registered full
module cd_upload_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [7:0]
) (
  input  logic                         CLK,
  input  logic                         nRESET,
  input  logic                         push,
  input  entry_t                       push_data,
  input  logic                         pop,
  output entry_t                       pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            push_ok;
  logic            pop_ok;
  logic [CW-1:0]   count_next;

  // A push into a full queue only lands when the head leaves in the same cycle
  always_comb begin
    pop_ok     = pop && (count != '0);
    push_ok    = push && (!full || pop_ok);
    count_next = count;
    if (push_ok && !pop_ok)
      count_next = count + CW'(1);
    else if (!push_ok && pop_ok)
      count_next = count - CW'(1);
  end

  // Pointers wrap naturally because the depth is a power of two
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
    end
  end

  // Entry storage needs no reset; count gates every read
  always_ff @(posedge CLK) begin
    if (push_ok)
      mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign empty    = (count == '0);

endmodule

// File: rtl/cd_upload_wr.sv
// rtl/cd_upload_wr.sv - upload-zone write router; CD_UPLOAD_OVF_EN builds the overflow flag/counter
module cd_upload_wr
  import cd_pkg::*;
#(
  parameter int                  FIFO_DEPTH = 4,
  parameter logic [SDRAM_AW-1:0] SPR_BASE   = 25'h0400000,
  parameter logic [SDRAM_AW-1:0] PCM_BASE   = 25'h0800000
) (
  input  logic                CLK,
  input  logic                nRESET,
  input  logic                WR_SPR,
  input  logic                WR_PCM,
  input  logic                WR_Z80,
  input  logic                WR_FIX,
  input  logic [1:0]          BANK_SPR,
  input  logic                BANK_PCM,
  input  logic [19:1]         WR_ADDR,
  input  logic [15:0]         WR_DATA,
  output logic                MEM_REQ,
  input  logic                MEM_ACK,
  output logic [SDRAM_AW-1:0] MEM_ADDR,
  output logic [15:0]         MEM_DATA,
  output logic [1:0]          MEM_BE,
  output logic                Z80_WE,
  output logic [Z80_AW-1:0]   Z80_ADDR,
  output logic                FIX_WE,
  output logic [FIX_AW-1:0]   FIX_ADDR,
  output logic [7:0]          BYTE_DATA,
  output logic                FULL,
  output logic                OVF,
  output logic [7:0]          OVF_CNT
);

  localparam int CW = $clog2(FIFO_DEPTH+1);

  upload_state_t  state;
  logic           spr_win, pcm_win, z80_win, fix_win;
  logic           q_push;
  logic           mem_pop;
  upload_entry_t  q_in;
  upload_entry_t  q_head;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;

  // Fixed strobe priority SPR > PCM > Z80 > FIX, plus per-area address and lane mapping
  always_comb begin
    spr_win = WR_SPR;
    pcm_win = WR_PCM && !WR_SPR;
    z80_win = WR_Z80 && !WR_SPR && !WR_PCM;
    fix_win = WR_FIX && !WR_SPR && !WR_PCM && !WR_Z80;
    q_push  = spr_win || pcm_win;
    if (spr_win) begin
      q_in.addr = SPR_BASE[SDRAM_AW-1:1] + (SDRAM_AW-1)'({BANK_SPR, WR_ADDR});
      q_in.data = WR_DATA;
      q_in.be   = 2'b11;
    end else begin
      // Byte offset {BANK_PCM, WR_ADDR}: its LSB (WR_ADDR[1]) picks the lane
      q_in.addr = PCM_BASE[SDRAM_AW-1:1] + (SDRAM_AW-1)'({BANK_PCM, WR_ADDR[19:2]});
      q_in.data = {WR_DATA[7:0], WR_DATA[7:0]};
      q_in.be   = WR_ADDR[1] ? 2'b01 : 2'b10;
    end
  end

  // Only an ACK seen while the request is actually raised retires the head
  assign mem_pop = MEM_REQ && MEM_ACK && (state == ST_REQ) && !fifo_empty;

  cd_upload_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (upload_entry_t)
  ) u_fifo (
    .CLK       (CLK),
    .nRESET    (nRESET),
    .push      (q_push),
    .push_data (q_in),
    .pop       (mem_pop),
    .pop_data  (q_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign FULL = fifo_full;

  // SDRAM handshake: REQ holds the head entry on registered outputs, GAP forces one idle cycle
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state    <= ST_IDLE;
      MEM_REQ  <= 1'b0;
      MEM_ADDR <= '0;
      MEM_DATA <= '0;
      MEM_BE   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_count != '0)
            state <= ST_REQ;
        end
        ST_REQ: begin
          if (mem_pop) begin
            MEM_REQ <= 1'b0;
            state   <= ST_GAP;
          end else begin
            MEM_REQ  <= 1'b1;
            MEM_ADDR <= {q_head.addr, 1'b0};
            MEM_DATA <= q_head.data;
            MEM_BE   <= q_head.be;
          end
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          MEM_REQ <= 1'b0;
        end
      endcase
    end
  end

  // Z80/FIX writes bypass the queue: one-cycle enable with registered address and byte
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      Z80_WE    <= 1'b0;
      FIX_WE    <= 1'b0;
      Z80_ADDR  <= '0;
      FIX_ADDR  <= '0;
      BYTE_DATA <= '0;
    end else begin
      Z80_WE <= z80_win;
      FIX_WE <= fix_win;
      if (z80_win)
        Z80_ADDR <= WR_ADDR[Z80_AW:1];
      if (fix_win)
        FIX_ADDR <= WR_ADDR[FIX_AW:1];
      if (z80_win || fix_win)
        BYTE_DATA <= WR_DATA[7:0];
    end
  end

`ifdef CD_UPLOAD_OVF_EN
  logic [2:0] n_strobe;
  logic [2:0] n_drop;
  logic [8:0] cnt_sum;

  // Every losing strobe and every push refused by a full queue counts as one drop
  always_comb begin
    n_strobe = 3'(WR_SPR) + 3'(WR_PCM) + 3'(WR_Z80) + 3'(WR_FIX);
    n_drop   = (n_strobe != 3'd0) ? (n_strobe - 3'd1) : 3'd0;
    n_drop   = n_drop + 3'(q_push && fifo_full && !mem_pop);
    cnt_sum  = {1'b0, OVF_CNT} + 9'(n_drop);
  end

  // Sticky flag and saturating drop counter, cleared only by reset
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      OVF     <= 1'b0;
      OVF_CNT <= '0;
    end else if (n_drop != 3'd0) begin
      OVF     <= 1'b1;
      OVF_CNT <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    end
  end
`else
  assign OVF     = 1'b0;
  assign OVF_CNT = 8'h00;
`endif

endmodule
